// File: rtl/mips_dmem_arb_pkg.sv
// Shared types and helpers for the data-RAM arbiter and its dump sequencer.
package mips_dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] byte_swap32(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

// File: rtl/mips_dump_seq.sv
// Dump sequencer: bursts dump_count words out of data RAM as a valid/ready stream,
// reading only in cycles where the arbiter grants it the RAM port.
module mips_dump_seq
  import mips_dmem_arb_pkg::*;
#(
  parameter bit SWAP_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_grant,
  input  logic [31:0] mem_readdata,
  input  logic        dump_start,
  input  logic [31:0] dump_base,
  input  logic [7:0]  dump_count,
  input  logic        dump_ready,
  output arb_state_t  state,
  output logic [31:0] cur_addr,
  output logic        dump_busy,
  output logic        dump_valid,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_done
);

  arb_state_t  state_reg, state_next;
  logic [31:0] cur_addr_reg, cur_addr_next;
  logic [7:0]  remaining_reg, remaining_next;
  logic        valid_reg, valid_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] data_reg, data_next;
  logic        done_reg, done_next;
  logic [31:0] fetch_word;

  generate
    if (SWAP_ENDIAN) begin : g_swap
      assign fetch_word = byte_swap32(mem_readdata);
    end else begin : g_noswap
      assign fetch_word = mem_readdata;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      valid_reg     <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      remaining_reg <= remaining_next;
      valid_reg     <= valid_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    valid_next     = valid_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dump_start) begin
          if (dump_count != 8'd0) begin
            cur_addr_next  = dump_base & ~32'(WORD_BYTES - 1);
            remaining_next = dump_count;
            state_next     = FETCH;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      FETCH: begin
        if (host_grant) begin
          data_next      = fetch_word;
          addr_next      = cur_addr_reg;
          valid_next     = 1'b1;
          cur_addr_next  = cur_addr_reg + 32'(WORD_BYTES);
          remaining_next = remaining_reg - 8'd1;
          state_next     = HOLD;
        end
      end
      HOLD: begin
        // Word stays presented until the consumer takes it.
        if (dump_ready) begin
          valid_next = 1'b0;
          if (remaining_reg == 8'd0) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign state      = state_reg;
  assign cur_addr   = cur_addr_reg;
  assign dump_busy  = (state_reg != IDLE);
  assign dump_valid = valid_reg;
  assign dump_addr  = addr_reg;
  assign dump_data  = data_reg;
  assign dump_done  = done_reg;

endmodule

// File: rtl/mips_dmem_arbiter.sv
// Data-RAM arbiter: CPU has priority, the dump sequencer uses idle cycles and
// can steal one cycle (by gating the CPU clock enable) after prolonged starvation.
module mips_dmem_arbiter
  import mips_dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter bit          SWAP_ENDIAN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_clk_enable,
  output logic        cpu_clk_enable,
  input  logic        cpu_active,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        dump_start,
  input  logic [31:0] dump_base,
  input  logic [7:0]  dump_count,
  output logic        dump_busy,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_done
);

  localparam logic [7:0] STARVE_LAST = 8'(STARVE_LIMIT - 1);

  arb_state_t  state;
  logic [31:0] cur_addr;
  logic        in_fetch;
  logic        host_grant;
  logic        steal_reg, steal_next;
  logic [7:0]  starve_cnt_reg, starve_cnt_next;

  assign in_fetch   = (state == FETCH);
  assign host_grant = in_fetch & (steal_reg | ~cpu_active | ~(cpu_read | cpu_write));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      steal_reg      <= 1'b0;
      starve_cnt_reg <= '0;
    end else begin
      steal_reg      <= steal_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // A steal lasts one cycle; the forced grant in that cycle clears the count.
  always_comb begin
    steal_next      = 1'b0;
    starve_cnt_next = '0;
    if (in_fetch && !host_grant) begin
      if (starve_cnt_reg == STARVE_LAST) begin
        steal_next = 1'b1;
      end else begin
        starve_cnt_next = starve_cnt_reg + 8'd1;
      end
    end
  end

  assign cpu_clk_enable = ext_clk_enable & ~steal_reg;
  assign cpu_readdata   = mem_readdata;
  assign mem_address    = host_grant ? cur_addr : cpu_address;
  assign mem_read       = host_grant ? 1'b1 : cpu_read;
  assign mem_write      = host_grant ? 1'b0 : cpu_write;
  assign mem_writedata  = cpu_writedata;

  mips_dump_seq #(
    .SWAP_ENDIAN(SWAP_ENDIAN)
  ) u_seq (
    .clk         (clk),
    .reset       (reset),
    .host_grant  (host_grant),
    .mem_readdata(mem_readdata),
    .dump_start  (dump_start),
    .dump_base   (dump_base),
    .dump_count  (dump_count),
    .dump_ready  (dump_ready),
    .state       (state),
    .cur_addr    (cur_addr),
    .dump_busy   (dump_busy),
    .dump_valid  (dump_valid),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data),
    .dump_done   (dump_done)
  );

endmodule
